// File: rtl/sfx_scheduler.sv
// Buzzer sound-effect scheduler: edge-detected requests, one-deep pending queue,
// fixed-priority arbitration with preemption, and ROM-driven note sequencing.
module sfx_scheduler #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned MAX_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enabled,
  input  logic [3:0] req,
  output logic [5:0] note,
  output logic       busy,
  output logic [1:0] cur_id,
  output logic       done
);

  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam int unsigned StepW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       req_q;
  logic [3:0]       pend_q, pend_d;
  logic [1:0]       id_q, id_d;
  logic [StepW-1:0] step_q, step_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [5:0]       dur_q, dur_d;
  logic [5:0]       note_q, note_d;

  logic [3:0]  rise;
  logic [3:0]  clr;
  logic [1:0]  win_id;
  logic        preempt;
  logic [11:0] cur_entry, nxt_entry;
  logic [5:0]  cur_dur;
  logic        has_next;
  logic        step_end;

  // Entry format {note[5:0], dur[5:0]}; dur==0 ends the list.
  function automatic logic [11:0] rom_entry(input logic [1:0] id, input int unsigned idx);
    logic [11:0] e;
    e = '0;
    unique case (id)
      2'd3: case (idx)
        0: e = {6'd10, 6'd3};
        1: e = {6'd11, 6'd3};
        2: e = {6'd12, 6'd6};
        default: e = '0;
      endcase
      2'd2: case (idx)
        0: e = {6'd7, 6'd2};
        1: e = {6'd8, 6'd2};
        2: e = {6'd9, 6'd2};
        default: e = '0;
      endcase
      2'd1: case (idx)
        0: e = {6'd3, 6'd4};
        1: e = {6'd1, 6'd4};
        default: e = '0;
      endcase
      2'd0: case (idx)
        0: e = {6'd1, 6'd2};
        1: e = {6'd2, 6'd2};
        2: e = {6'd3, 6'd2};
        3: e = {6'd4, 6'd2};
        4: e = {6'd5, 6'd2};
        5: e = {6'd6, 6'd2};
        default: e = '0;
      endcase
    endcase
    if (idx >= MAX_STEPS) e = '0;
    return e;
  endfunction

  assign rise = req & ~req_q;

  always_comb begin
    win_id = 2'd0;
    if (pend_q[3])      win_id = 2'd3;
    else if (pend_q[2]) win_id = 2'd2;
    else if (pend_q[1]) win_id = 2'd1;
  end

  assign preempt   = (|pend_q) && (win_id > id_q);
  assign cur_entry = rom_entry(id_q, 32'(step_q));
  assign nxt_entry = rom_entry(id_q, 32'(step_q) + 32'd1);
  assign cur_dur   = cur_entry[5:0];
  assign has_next  = (step_q != StepW'(MAX_STEPS - 1)) && (nxt_entry[5:0] != 6'd0);

  // With a following step, end one cycle early: the LOAD cycle completes this note's period.
  assign step_end = (dur_q == cur_dur - 6'd1) &&
                    (tick_q == (has_next ? TickW'(TICK_DIV - 2) : TickW'(TICK_DIV - 1)));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    step_d  = step_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    note_d  = note_q;
    clr     = 4'b0000;

    if (!enabled) begin
      state_d = StIdle;
      note_d  = 6'd0;
      step_d  = '0;
      tick_d  = '0;
      dur_d   = 6'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          note_d = 6'd0;
          if (|pend_q) begin
            state_d = StLoad;
            id_d    = win_id;
            step_d  = '0;
            clr     = 4'b0001 << win_id;
          end
        end
        StLoad: begin
          if (preempt) begin
            id_d   = win_id;
            step_d = '0;
            clr    = 4'b0001 << win_id;
          end else begin
            state_d = StPlay;
            note_d  = cur_entry[11:6];
            tick_d  = '0;
            dur_d   = 6'd0;
          end
        end
        StPlay: begin
          if (preempt) begin
            state_d = StLoad;
            id_d    = win_id;
            step_d  = '0;
            clr     = 4'b0001 << win_id;
          end else if (step_end) begin
            if (has_next) begin
              state_d = StLoad;
              step_d  = step_q + StepW'(1);
            end else begin
              state_d = StDone;
              note_d  = 6'd0;
            end
          end else if (tick_q == TickW'(TICK_DIV - 1)) begin
            tick_d = '0;
            dur_d  = dur_q + 6'd1;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        StDone: begin
          state_d = StIdle;
          note_d  = 6'd0;
        end
      endcase
    end

    // Set wins over clear so a rise in the LOAD-entry cycle queues a repeat.
    pend_d = enabled ? ((pend_q & ~clr) | rise) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= 4'b0000;
      pend_q  <= 4'b0000;
      id_q    <= 2'd0;
      step_q  <= '0;
      tick_q  <= '0;
      dur_q   <= 6'd0;
      note_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      pend_q  <= pend_d;
      id_q    <= id_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      note_q  <= note_d;
    end
  end

  assign note   = note_q;
  assign busy   = (state_q == StLoad) || (state_q == StPlay);
  assign cur_id = id_q;
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_sfx_scheduler.sv
// Directed bench for sfx_scheduler with TICK_DIV=4: timing, priority, queueing,
// disable and asynchronous reset behaviour against hand-derived note timelines.
module tb_sfx_scheduler;

  localparam int unsigned TickDiv = 4;

  logic       clk;
  logic       rst_n;
  logic       enabled;
  logic [3:0] req;
  logic [5:0] note;
  logic       busy;
  logic [1:0] cur_id;
  logic       done;

  int checks = 0;
  int errors = 0;

  int fx_note [4][6] = '{'{1, 2, 3, 4, 5, 6}, '{3, 1, 0, 0, 0, 0},
                         '{7, 8, 9, 0, 0, 0}, '{10, 11, 12, 0, 0, 0}};
  int fx_dur  [4][6] = '{'{2, 2, 2, 2, 2, 2}, '{4, 4, 0, 0, 0, 0},
                         '{2, 2, 2, 0, 0, 0}, '{3, 3, 6, 0, 0, 0}};

  sfx_scheduler #(
    .TICK_DIV (TickDiv),
    .MAX_STEPS(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enabled(enabled),
    .req    (req),
    .note   (note),
    .busy   (busy),
    .cur_id (cur_id),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks note/busy/done for a run of cycles, leaving time at the next cycle.
  task automatic expect_note(input string tag, input int n, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_eq({tag, " note"}, 32'(note), 32'(n));
      check_eq({tag, " busy"}, 32'(busy), 32'd1);
      check_eq({tag, " done"}, 32'(done), 32'd0);
      step();
    end
  endtask

  // Plays a full effect from its first audible cycle through the DONE cycle.
  task automatic play_fx(input string tag, input int id);
    for (int k = 0; k < 6 && fx_dur[id][k] != 0; k++) begin
      check_eq({tag, " cur_id"}, 32'(cur_id), 32'(id));
      expect_note(tag, fx_note[id][k], fx_dur[id][k] * TickDiv);
    end
    check_eq({tag, " done pulse"}, 32'(done), 32'd1);
    check_eq({tag, " done note"}, 32'(note), 32'd0);
    check_eq({tag, " done busy"}, 32'(busy), 32'd0);
    step();
    check_eq({tag, " post done"}, 32'(done), 32'd0);
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_eq({tag, " note"}, 32'(note), 32'd0);
      check_eq({tag, " busy"}, 32'(busy), 32'd0);
      check_eq({tag, " done"}, 32'(done), 32'd0);
      step();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    enabled = 1'b1;
    req     = 4'b0000;
    repeat (3) step();
    check_eq("reset note", 32'(note), 32'd0);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset cur_id", 32'(cur_id), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();

    // Single hit: LOAD one cycle after pend, note the cycle after that.
    req = 4'b0001;
    step();
    req = 4'b0000;
    check_eq("hit pend busy", 32'(busy), 32'd0);
    step();
    check_eq("hit load busy", 32'(busy), 32'd1);
    check_eq("hit load note", 32'(note), 32'd0);
    step();
    play_fx("hit", 0);
    expect_idle("hit after", 4);

    // Preemption of hit by win five cycles into step 0.
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    step();
    expect_note("pre hit", 1, 5);
    req = 4'b1000;
    expect_note("pre hold", 1, 1);
    req = 4'b0000;
    expect_note("pre hold", 1, 2);
    play_fx("pre win", 3);
    expect_idle("pre after", 6);

    // Simultaneous miss+pause rises: pause first, then miss after three quiet cycles.
    req = 4'b0110;
    step();
    req = 4'b0000;
    step();
    check_eq("queue first id", 32'(cur_id), 32'd2);
    step();
    play_fx("queue pause", 2);
    check_eq("queue idle busy", 32'(busy), 32'd0);
    step();
    check_eq("queue load busy", 32'(busy), 32'd1);
    check_eq("queue load note", 32'(note), 32'd0);
    check_eq("queue load id", 32'(cur_id), 32'd1);
    step();
    play_fx("queue miss", 1);
    expect_idle("queue after", 4);

    // One-deep queue: three hit rises during win yield a single hit afterwards.
    req = 4'b1000;
    step();
    req = 4'b0000;
    step();
    step();
    fork
      play_fx("deep win", 3);
      begin
        repeat (3) begin
          req[0] = 1'b1;
          step();
          req[0] = 1'b0;
          step();
        end
      end
    join
    check_eq("deep idle busy", 32'(busy), 32'd0);
    step();
    check_eq("deep load id", 32'(cur_id), 32'd0);
    check_eq("deep load busy", 32'(busy), 32'd1);
    step();
    play_fx("deep hit", 0);
    expect_idle("deep after", 10);

    // Disable during pause step 1; a rise while disabled stays silent.
    req = 4'b0100;
    step();
    req = 4'b0000;
    step();
    step();
    expect_note("dis p0", 7, 8);
    expect_note("dis p1", 8, 3);
    enabled = 1'b0;
    step();
    check_eq("dis note", 32'(note), 32'd0);
    check_eq("dis busy", 32'(busy), 32'd0);
    check_eq("dis done", 32'(done), 32'd0);
    req = 4'b0001;
    step();
    step();
    enabled = 1'b1;
    expect_idle("dis reen", 20);
    req = 4'b0000;
    step();

    // Asynchronous reset mid-note takes effect between clock edges.
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    step();
    expect_note("arst miss", 3, 5);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst note", 32'(note), 32'd0);
    check_eq("arst busy", 32'(busy), 32'd0);
    check_eq("arst cur_id", 32'(cur_id), 32'd0);
    check_eq("arst done", 32'(done), 32'd0);
    step();
    rst_n = 1'b1;
    expect_idle("arst after", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
